senha_gen_multi: RTL
====================

# senha_gen_multi

- Parametrised multi-digit password generator for the bomb-defusal game.
- An LFSR of configurable width and taps is stepped once per clk_1Hz edge. Candidate digits are taken from its low bits and accepted only if in range 0..DIGIT_MAX; out-of-range candidates are rejected.
- Accepted digits are packed into an atomic password word with a valid/busy status pair.
- The block sits between the game controller (issues `gen_req` at round start) and the keypad comparator (consumes `senha` when `valid`=1).

## Interface
- `LFSR_W`, 11: LFSR width (≥ DIGIT_W, ≤ 32).
- `TAP_A`, 10: first feedback tap index.
- `TAP_B`, 8: second feedback tap index.
- `SEED`, 11'h555 (LFSR_W bits): LFSR value loaded at reset.
- `DIGITS`, 4: number of digits per password (1..8).
- `DIGIT_W`, 4: bits per digit.
- `DIGIT_MAX`, 9: largest accepted digit value (< 2^DIGIT_W).

Ports:
- `clk_1Hz`  in  1  game clock; reset reset, asynchronous, active-high; clock clk_1Hz.
- `reset`  in  1  asynchronous, active-high reset.
- `gen_req`  in  1  generate-new-password request; sampled only in IDLE/DONE.
- `busy`  out  1  generation in progress.
- `valid`  out  1  `senha` holds a complete password.
- `senha`  out  DIGITS*DIGIT_W  packed password; digit 0 in the LSBs.
- `rej_cnt`  out  DIGIT_W+1  consecutive rejections for the current digit (debug).

## Operation
- **Reset values:** `lfsr`=SEED, state=IDLE, `busy`=0, `valid`=0, `senha`=0, `rej_cnt`=0, digit index=0, shadow digits=0.
- **States:** IDLE, STEP, DONE.
- **IDLE/DONE, `gen_req`=1:** → STEP, `busy`=1, `valid`=0, index=0, `rej_cnt`=0. The LFSR does not move on this edge. `senha` keeps its old value.
- **STEP, every edge:**
  - Next LFSR value: `nxt` = {lfsr[LFSR_W-2:0], lfsr[TAP_A]^lfsr[TAP_B]}.
  - Zero-lock guard: if `lfsr`==0, `nxt` is 1 instead.
  - `lfsr`<=`nxt`; candidate `c` = `nxt`[DIGIT_W-1:0].
- **Accept rule:**
  - `c`≤DIGIT_MAX: store `c` in shadow digit[index], index++, `rej_cnt`=0.
  - Otherwise `rej_cnt`++.
  - If the rejection makes `rej_cnt` reach 2^DIGIT_W, store 0 in digit[index] instead, index++, `rej_cnt`=0.
- **Completion:** on the edge that stores digit DIGITS-1:
  - `senha`<=all shadow digits including the new one;
  - `valid`=1, `busy`=0, → DONE.
- **Request during STEP:** `gen_req` is ignored; no restart and no queuing.
- **DONE:** holds `senha` and `valid` until the next accepted `gen_req`.
- The LFSR is never reseeded between requests; each password continues the sequence.
- Reset mid-generation aborts immediately; all registers return to their reset values.

## Timing
- `gen_req` accepted at edge k. LFSR steps occur at edges k+1 … k+N, where N = DIGITS + number of rejections.
- `valid` rises and `senha` updates at edge k+N. Minimum latency is DIGITS cycles after acceptance.
- `senha` never shows a partial password: the update is a single-edge atomic load.
- `busy`=1 exactly from edge k to edge k+N; `busy` and `valid` are never both 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SENHA_AUTOGEN_EN`.
- **Defined:** after reset release, the first clk_1Hz edge behaves as an accepted `gen_req` (→ STEP). A password is produced without a request, and `gen_req` is ignored on that edge.
- **Undefined:** the block stays in IDLE with `valid`=0 until `gen_req`.

## Test plan
- **Defaults, macro off.** Reset, then `gen_req` at edge k.
  - LFSR goes 0x2AA (c=10, rejected), 0x554 (4), 0x2A8 (8), 0x550 (0), 0x2A0 (0).
  - Required: `valid`=1 at k+5, `senha`=16'h0084, `busy` high for edges k..k+5.
- **Second request** from the previous state, `gen_req` at edge j.
  - LFSR goes 0x540, 0x280, 0x500, 0x200, all candidates 0.
  - Required: `senha`=16'h0000 and `valid` at j+4; `senha` held at 16'h0084 until edge j+4.
- **SEED=0.** Zero guard gives LFSR 1, 2, 4, 8.
  - Required: `senha`=16'h8421 after 4 steps; the LFSR never stays at 0.
- **`gen_req` held high during STEP.** Required: no restart, result identical to the first scenario. Then reset asserted at k+2: all outputs read 0 asynchronously and LFSR=0x555.
- **`SENHA_AUTOGEN_EN` defined, no `gen_req`.** Required: `valid`=1 and `senha`=16'h0084 five edges after the first post-reset edge.
- **DIGIT_MAX=0, DIGIT_W=2.** Required: every stored digit is 0; `rej_cnt` never exceeds 4; a digit is forced to 0 after 4 consecutive rejections.

Source files
------------

// File: rtl/senha_gen_multi.sv
// ----------------------------------------------------------------------------
// senha_gen_multi
//   Multi-digit password generator for the bomb-defusal game. A Fibonacci-style
//   LFSR is stepped once per clk_1Hz edge while generating. Each step offers
//   its low DIGIT_W bits as a candidate digit, and the candidate is accepted
//   only if it is <= DIGIT_MAX. The accepted digits collect in a shadow
//   register. The complete password is then loaded into `senha` in a single
//   edge, so the output never shows a partial password.
//
//   Optional feature macro: SENHA_AUTOGEN_EN. When it is defined, the first
//   clk_1Hz edge after reset release starts a generation without `gen_req`.
//
// Ports
//   clk_1Hz  in   game clock
//   reset    in   asynchronous, active-high reset
//   gen_req  in   generate-new-password request (sampled in IDLE/DONE only)
//   busy     out  generation in progress
//   valid    out  `senha` holds a complete password
//   senha    out  DIGITS*DIGIT_W packed password, digit 0 in the LSBs
//   rej_cnt  out  consecutive rejections for the current digit (debug)
// ----------------------------------------------------------------------------
module senha_gen_multi #(
  parameter int unsigned        LFSR_W    = 11,
  parameter int unsigned        TAP_A     = 10,
  parameter int unsigned        TAP_B     = 8,
  parameter logic [LFSR_W-1:0]  SEED      = 11'h555,
  parameter int unsigned        DIGITS    = 4,
  parameter int unsigned        DIGIT_W   = 4,
  parameter int unsigned        DIGIT_MAX = 9
) (
  input  logic                        clk_1Hz,
  input  logic                        reset,
  input  logic                        gen_req,
  output logic                        busy,
  output logic                        valid,
  output logic [DIGITS*DIGIT_W-1:0]   senha,
  output logic [DIGIT_W:0]            rej_cnt
);

  localparam int unsigned          IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIGIT_W-1:0]   MAX_C    = DIGIT_W'(DIGIT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      state_q,  state_d;
  logic [LFSR_W-1:0]           lfsr_q,   lfsr_d;
  logic [IDX_W-1:0]            idx_q,    idx_d;
  logic [DIGIT_W:0]            rej_q,    rej_d;
  logic [DIGITS*DIGIT_W-1:0]   shadow_q, shadow_d;
  logic [DIGITS*DIGIT_W-1:0]   senha_q,  senha_d;
  logic                        busy_q,   busy_d;
  logic                        valid_q,  valid_d;

`ifdef SENHA_AUTOGEN_EN
  // Set by reset; marks the first edge after release as an implicit request.
  logic                        first_q,  first_d;
`endif

  logic                        start;
  logic                        fb;
  logic [LFSR_W-1:0]           lfsr_nxt;
  logic [DIGIT_W-1:0]          cand;
  logic [DIGIT_W:0]            rej_inc;
  logic                        store;
  logic [DIGIT_W-1:0]          store_val;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    idx_d     = idx_q;
    rej_d     = rej_q;
    shadow_d  = shadow_q;
    senha_d   = senha_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
`ifdef SENHA_AUTOGEN_EN
    first_d   = 1'b0;
    start     = gen_req | first_q;
`else
    start     = gen_req;
`endif
    store     = 1'b0;
    store_val = '0;

    // The all-zero state is a lock-up point of the XOR feedback, so it is
    // forced out to 1.
    fb       = lfsr_q[TAP_A] ^ lfsr_q[TAP_B];
    lfsr_nxt = (lfsr_q == '0) ? LFSR_W'(1) : {lfsr_q[LFSR_W-2:0], fb};
    cand     = lfsr_nxt[DIGIT_W-1:0];
    rej_inc  = rej_q + (DIGIT_W+1)'(1);

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = STEP;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          idx_d   = '0;
          rej_d   = '0;
        end
      end

      STEP: begin
        lfsr_d = lfsr_nxt;
        if (cand <= MAX_C) begin
          store     = 1'b1;
          store_val = cand;
        end else if (rej_inc[DIGIT_W]) begin
          // Rejection streak hit 2^DIGIT_W: force a 0 digit so that
          // generation always terminates.
          store     = 1'b1;
          store_val = '0;
        end else begin
          rej_d = rej_inc;
        end

        if (store) begin
          shadow_d[idx_q*DIGIT_W +: DIGIT_W] = store_val;
          rej_d = '0;
          if (idx_q == LAST_IDX) begin
            // Atomic load that includes the digit stored on this edge.
            senha_d = shadow_d;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      idx_q    <= '0;
      rej_q    <= '0;
      shadow_q <= '0;
      senha_q  <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef SENHA_AUTOGEN_EN
      first_q  <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      idx_q    <= idx_d;
      rej_q    <= rej_d;
      shadow_q <= shadow_d;
      senha_q  <= senha_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
`ifdef SENHA_AUTOGEN_EN
      first_q  <= first_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign senha   = senha_q;
  assign rej_cnt = rej_q;

endmodule
